// File: rtl/fft_usb_pkg.sv
// fft_usb_pkg: shared constants, frame packing and FSM state type for the FFT-to-FT2232H
// streaming path.
//   FRAME_BYTES / FRAME_WIDTH : size of one on-the-wire bin frame
//   HDR                       : frame sync nibble, lets the host re-align on a byte stream
//   pack_frame()              : {HDR, ctr, re, im}, sent MSB-first
//   tx_state_e                : transmit FSM states
package fft_usb_pkg;

  localparam int unsigned FRAME_BYTES = 8;
  localparam int unsigned FRAME_WIDTH = 64;
  localparam logic [3:0]  HDR         = 4'hA;

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } tx_state_e;

  function automatic logic [FRAME_WIDTH-1:0] pack_frame(input logic [9:0]  ctr,
                                                        input logic [24:0] re,
                                                        input logic [24:0] im);
    return {HDR, ctr, re, im};
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// frame_fifo: synchronous first-word-fall-through FIFO holding packed bin frames.
//   clk_i, rst_n : clock, synchronous active-low reset (clears pointers and count)
//   push_i       : write data_i at the tail (ignored when full)
//   data_i       : frame to write
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry, valid whenever empty_o is low
//   count_o      : number of stored entries, 0..DEPTH
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
module frame_fifo
  import fft_usb_pkg::*;
#(
  parameter int unsigned WIDTH = FRAME_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fft_usb_tx.sv
// fft_usb_tx: streams FFT bins to an FT2232H in synchronous-FIFO mode, one 8-byte frame per
// bin, MSB-first. Runs entirely in the ft_clkout domain.
//   clk_i, rst_n   : 60 MHz FT2232H CLKOUT, synchronous active-low reset
//   valid_i        : bin present on ctr_i/re_i/im_i
//   ready_o        : frame FIFO has room (low during and one cycle after reset)
//   ctr_i, re_i, im_i : bin index and signed real/imag parts
//   ft_txe_n_i     : low = FT2232H can take a byte
//   ft_wr_n_o      : low = ft_data_o carries a valid byte
//   ft_data_o      : byte to FT2232H
//   ft_data_oe_o   : pad output enable, the inverse of ft_wr_n_o
//   overflow_o     : sticky, a bin was offered while ready_o was low
module fft_usb_tx
  import fft_usb_pkg::*;
#(
  parameter int unsigned N_WIDTH    = 10,
  parameter int unsigned DATA_WIDTH = 25,
  parameter int unsigned USB_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [N_WIDTH-1:0]    ctr_i,
  input  logic [DATA_WIDTH-1:0] re_i,
  input  logic [DATA_WIDTH-1:0] im_i,
  input  logic                  ft_txe_n_i,
  output logic                  ft_wr_n_o,
  output logic [USB_WIDTH-1:0]  ft_data_o,
  output logic                  ft_data_oe_o,
  output logic                  overflow_o
);

  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IDX_W    = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  // Registered state
  tx_state_e              r_state;
  logic                   r_wr_n;
  logic [FRAME_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]       r_byte_idx;
  logic                   r_overflow;
  logic                   r_rst_n_q;

  // Next-state and FIFO wiring
  tx_state_e              w_state_d;
  logic                   w_wr_n_d;
  logic [FRAME_WIDTH-1:0] w_shift_d;
  logic [IDX_W-1:0]       w_byte_idx_d;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_byte_acc;
  logic [FRAME_WIDTH-1:0] w_frame;
  logic [FRAME_WIDTH-1:0] w_fifo_head;
  logic [CNT_W-1:0]       w_fifo_count;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;

  assign w_frame = pack_frame(ctr_i, re_i, im_i);

  // r_rst_n_q keeps ready_o low for the first cycle after reset release.
  assign ready_o = r_rst_n_q && (w_fifo_count != CNT_W'(FIFO_DEPTH));
  // Same condition as ready_o, expressed through the FIFO's full flag.
  assign w_push  = valid_i && r_rst_n_q && !w_fifo_full;

  assign w_byte_acc   = !r_wr_n && !ft_txe_n_i;
  assign ft_wr_n_o    = r_wr_n;
  assign ft_data_oe_o = !r_wr_n;
  assign ft_data_o    = r_shift[FRAME_WIDTH-1 -: USB_WIDTH];
  assign overflow_o   = r_overflow;

  frame_fifo #(
    .WIDTH (FRAME_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_frame_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .data_i  (w_frame),
    .pop_i   (w_pop),
    .head_o  (w_fifo_head),
    .count_o (w_fifo_count),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  always_comb begin
    w_state_d    = r_state;
    w_wr_n_d     = r_wr_n;
    w_shift_d    = r_shift;
    w_byte_idx_d = r_byte_idx;
    w_pop        = 1'b0;

    case (r_state)
      IDLE: begin
        w_wr_n_d = 1'b1;
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_shift_d    = w_fifo_head;
          w_byte_idx_d = '0;
          w_wr_n_d     = 1'b0;
          w_state_d    = SEND;
        end
      end
      SEND: begin
        // A refused byte leaves everything untouched, so ft_data_o holds.
        if (w_byte_acc) begin
          if (r_byte_idx != LAST_IDX) begin
            w_shift_d    = r_shift << USB_WIDTH;
            w_byte_idx_d = r_byte_idx + IDX_W'(1);
          end else if (!w_fifo_empty) begin
            // Next frame loads on the same edge as the last byte: no gap on the bus.
            w_pop        = 1'b1;
            w_shift_d    = w_fifo_head;
            w_byte_idx_d = '0;
          end else begin
            w_wr_n_d  = 1'b1;
            w_state_d = IDLE;
          end
        end
      end
      default: begin
        w_wr_n_d  = 1'b1;
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wr_n     <= 1'b1;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_overflow <= 1'b0;
      r_rst_n_q  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wr_n     <= w_wr_n_d;
      r_shift    <= w_shift_d;
      r_byte_idx <= w_byte_idx_d;
      r_rst_n_q  <= 1'b1;
      if (valid_i && !ready_o) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_usb_tx.sv
// tb_fft_usb_tx: directed self-checking bench for fft_usb_tx.
module tb_fft_usb_tx;

  logic        clk_i;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [9:0]  ctr_i;
  logic [24:0] re_i;
  logic [24:0] im_i;
  logic        ft_txe_n_i;
  logic        ft_wr_n_o;
  logic [7:0]  ft_data_o;
  logic        ft_data_oe_o;
  logic        overflow_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic       mon_en = 1'b0;
  logic [7:0] rx_q [$];
  int         rx_t [$];

  fft_usb_tx #(
    .N_WIDTH    (10),
    .DATA_WIDTH (25),
    .USB_WIDTH  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .ctr_i        (ctr_i),
    .re_i         (re_i),
    .im_i         (im_i),
    .ft_txe_n_i   (ft_txe_n_i),
    .ft_wr_n_o    (ft_wr_n_o),
    .ft_data_o    (ft_data_o),
    .ft_data_oe_o (ft_data_oe_o),
    .overflow_o   (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Inputs change only just after a rising edge, so what is seen here is what the next edge sees.
  always @(negedge clk_i) begin
    if (mon_en && rst_n === 1'b1 && ft_wr_n_o === 1'b0 && ft_txe_n_i === 1'b0) begin
      rx_q.push_back(ft_data_o);
      rx_t.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] mk_frame(input logic [9:0] c, input logic [24:0] r,
                                           input logic [24:0] m);
    return {4'hA, c, r, m};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [63:0] f, input int b);
    return f[63-8*b -: 8];
  endfunction

  task automatic push_bin(input logic [9:0] c, input logic [24:0] r, input logic [24:0] m);
    valid_i = 1'b1;
    ctr_i   = c;
    re_i    = r;
    im_i    = m;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic mon_restart();
    rx_q.delete();
    rx_t.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    valid_i    = 1'b0;
    ctr_i      = '0;
    re_i       = '0;
    im_i       = '0;
    ft_txe_n_i = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (ft_wr_n_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_wr_n: got %b expected 1", ft_wr_n_o);
    end
    n_checks++;
    if (ft_data_o !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00", ft_data_o);
    end
    n_checks++;
    if (ft_data_oe_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_oe: got %b expected 0", ft_data_oe_o);
    end
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0", ready_o);
    end
    n_checks++;
    if (overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow_o);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_release: got %b expected 1", ready_o);
    end
    n_checks++;
    if (ft_wr_n_o !== 1'b1) begin
      n_fail++; $display("FAIL idle_wr_n_after_release: got %b expected 1", ft_wr_n_o);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_b [8];
    exp_b = '{8'hA5, 8'h57, 8'h57, 8'h9B, 8'hDE, 8'h12, 8'h34, 8'h56};
    mon_en     = 1'b0;
    ft_txe_n_i = 1'b0;
    push_bin(10'h155, 25'h1ABCDEF, 25'h0123456);
    n_checks++;
    if (ft_wr_n_o !== 1'b1) begin
      n_fail++; $display("FAIL single_latency_wr_n: got %b expected 1", ft_wr_n_o);
    end
    tick();
    for (int b = 0; b < 8; b++) begin
      n_checks++;
      if ({ft_wr_n_o, ft_data_o} !== {1'b0, exp_b[b]}) begin
        n_fail++;
        $display("FAIL single_byte%0d: got wr_n=%b data=%h expected wr_n=0 data=%h",
                 b, ft_wr_n_o, ft_data_o, exp_b[b]);
      end
      tick();
    end
    n_checks++;
    if ({ft_wr_n_o, ft_data_oe_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_end: got wr_n=%b oe=%b expected wr_n=1 oe=0", ft_wr_n_o, ft_data_oe_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] fr [4];
    logic        ready_dropped;
    int          gaps;
    ready_dropped = 1'b0;
    gaps          = 0;
    ft_txe_n_i    = 1'b0;
    mon_restart();
    for (int i = 0; i < 4; i++) begin
      fr[i] = mk_frame(10'(i + 16), 25'h1000000 | 25'(i * 3), 25'h0FFFF00 ^ 25'(i));
      n_checks++;
      if (ready_o !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready_push%0d: got %b expected 1", i, ready_o);
      end
      push_bin(10'(i + 16), 25'h1000000 | 25'(i * 3), 25'h0FFFF00 ^ 25'(i));
    end
    for (int k = 0; k < 50; k++) begin
      if (ready_o !== 1'b1) ready_dropped = 1'b1;
      tick();
    end
    n_checks++;
    if (ready_dropped !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready_never_low: got dropped=%b expected 0", ready_dropped);
    end
    n_checks++;
    if (rx_q.size() != 32) begin
      n_fail++; $display("FAIL b2b_byte_count: got %0d expected 32", rx_q.size());
    end else begin
      for (int j = 0; j < 32; j++) begin
        n_checks++;
        if (rx_q[j] !== frame_byte(fr[j/8], j % 8)) begin
          n_fail++;
          $display("FAIL b2b_byte%0d: got %h expected %h", j, rx_q[j], frame_byte(fr[j/8], j % 8));
        end
        if (j > 0 && rx_t[j] != rx_t[j-1] + 1) gaps++;
      end
      n_checks++;
      if (gaps != 0) begin
        n_fail++; $display("FAIL b2b_contiguous: got %0d gaps expected 0", gaps);
      end
    end
    mon_en = 1'b0;
  endtask

  task automatic test_stall();
    logic [63:0] fr;
    fr         = mk_frame(10'h2C3, 25'h0F0F0F0, 25'h1555555);
    ft_txe_n_i = 1'b0;
    mon_restart();
    push_bin(10'h2C3, 25'h0F0F0F0, 25'h1555555);
    repeat (4) tick();
    ft_txe_n_i = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      n_checks++;
      if ({ft_wr_n_o, ft_data_o} !== {1'b0, frame_byte(fr, 3)}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got wr_n=%b data=%h expected wr_n=0 data=%h",
                 s, ft_wr_n_o, ft_data_o, frame_byte(fr, 3));
      end
    end
    ft_txe_n_i = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (rx_q.size() != 8) begin
      n_fail++; $display("FAIL stall_byte_count: got %0d expected 8", rx_q.size());
    end else begin
      for (int b = 0; b < 8; b++) begin
        n_checks++;
        if (rx_q[b] !== frame_byte(fr, b)) begin
          n_fail++; $display("FAIL stall_byte%0d: got %h expected %h", b, rx_q[b], frame_byte(fr, b));
        end
      end
    end
    mon_en = 1'b0;
  endtask

  // One frame moves straight into the shift register, so with the bus stalled the
  // source can place five bins before ready_o drops; the sixth is dropped.
  task automatic test_overflow();
    logic [63:0] fr [6];
    ft_txe_n_i = 1'b1;
    mon_restart();
    for (int i = 0; i < 6; i++) begin
      fr[i] = mk_frame(10'(i + 100), 25'(i * 1000 + 7), 25'h1F00000 | 25'(i));
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ready_o !== 1'b1) begin
        n_fail++; $display("FAIL ovf_ready_push%0d: got %b expected 1", i, ready_o);
      end
      push_bin(10'(i + 100), 25'(i * 1000 + 7), 25'h1F00000 | 25'(i));
    end
    n_checks++;
    if ({ready_o, overflow_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL ovf_full: got ready=%b overflow=%b expected ready=0 overflow=0",
               ready_o, overflow_o);
    end
    push_bin(10'(105), 25'(5 * 1000 + 7), 25'h1F00000 | 25'(5));
    n_checks++;
    if ({ready_o, overflow_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovf_drop: got ready=%b overflow=%b expected ready=0 overflow=1",
               ready_o, overflow_o);
    end
    repeat (3) tick();
    ft_txe_n_i = 1'b0;
    repeat (60) tick();
    n_checks++;
    if (rx_q.size() != 40) begin
      n_fail++; $display("FAIL ovf_byte_count: got %0d expected 40", rx_q.size());
    end else begin
      for (int j = 0; j < 40; j++) begin
        n_checks++;
        if (rx_q[j] !== frame_byte(fr[j/8], j % 8)) begin
          n_fail++;
          $display("FAIL ovf_byte%0d: got %h expected %h", j, rx_q[j], frame_byte(fr[j/8], j % 8));
        end
      end
    end
    n_checks++;
    if (overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow_o);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_midframe_reset();
    logic [63:0] fa;
    logic [63:0] fb;
    fa         = mk_frame(10'h0F0, 25'h1234567, 25'h0765432);
    fb         = mk_frame(10'h30C, 25'h0000001, 25'h1FFFFFF);
    ft_txe_n_i = 1'b0;
    mon_restart();
    push_bin(10'h0F0, 25'h1234567, 25'h0765432);
    repeat (5) tick();
    n_checks++;
    if (ft_data_o !== frame_byte(fa, 4)) begin
      n_fail++; $display("FAIL rst_pre_byte4: got %h expected %h", ft_data_o, frame_byte(fa, 4));
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({ft_wr_n_o, ft_data_o, ft_data_oe_o, ready_o, overflow_o} !== {1'b1, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got wr_n=%b data=%h oe=%b ready=%b ovf=%b expected 1 00 0 0 0",
               ft_wr_n_o, ft_data_o, ft_data_oe_o, ready_o, overflow_o);
    end
    n_checks++;
    if (rx_q.size() != 4) begin
      n_fail++; $display("FAIL rst_bytes_before: got %0d expected 4", rx_q.size());
    end
    rx_q.delete();
    rx_t.delete();
    tick();
    n_checks++;
    if ({ft_wr_n_o, ready_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_fifo_empty: got wr_n=%b ready=%b expected wr_n=1 ready=1",
               ft_wr_n_o, ready_o);
    end
    push_bin(10'h30C, 25'h0000001, 25'h1FFFFFF);
    repeat (20) tick();
    n_checks++;
    if (rx_q.size() != 8) begin
      n_fail++; $display("FAIL rst_after_count: got %0d expected 8", rx_q.size());
    end else begin
      for (int b = 0; b < 8; b++) begin
        n_checks++;
        if (rx_q[b] !== frame_byte(fb, b)) begin
          n_fail++; $display("FAIL rst_after_byte%0d: got %h expected %h", b, rx_q[b], frame_byte(fb, b));
        end
      end
    end
    mon_en = 1'b0;
  endtask

  // Source offers a bin at most every 8 clocks and waits on ready_o; the bus stalls ~10 %.
  task automatic test_sweep();
    int          sent;
    int          gap;
    int          bad;
    logic        offered;
    logic [63:0] got;
    logic [63:0] exp;
    sent = 0;
    gap  = 0;
    bad  = 0;
    mon_restart();
    for (int k = 0; k < 20000 && sent < 1024; k++) begin
      ft_txe_n_i = ($urandom_range(0, 9) == 0);
      offered    = (gap == 0) && (ready_o === 1'b1);
      valid_i    = offered;
      ctr_i      = 10'(sent);
      re_i       = 25'(sent * 37 + 5);
      im_i       = ~25'(sent);
      tick();
      if (offered) begin
        sent++;
        gap = 7;
      end else if (gap > 0) begin
        gap--;
      end
    end
    valid_i    = 1'b0;
    ft_txe_n_i = 1'b0;
    for (int k = 0; k < 200 && rx_q.size() < 8192; k++) tick();
    repeat (4) tick();
    n_checks++;
    if (sent != 1024) begin
      n_fail++; $display("FAIL sweep_sent: got %0d expected 1024", sent);
    end
    n_checks++;
    if (rx_q.size() != 8192) begin
      n_fail++; $display("FAIL sweep_byte_count: got %0d expected 8192", rx_q.size());
    end else begin
      for (int f = 0; f < 1024; f++) begin
        got = {rx_q[8*f], rx_q[8*f+1], rx_q[8*f+2], rx_q[8*f+3],
               rx_q[8*f+4], rx_q[8*f+5], rx_q[8*f+6], rx_q[8*f+7]};
        exp = mk_frame(10'(f), 25'(f * 37 + 5), ~25'(f));
        if (got !== exp) begin
          bad++;
          if (bad <= 4) $display("FAIL sweep_frame%0d: got %h expected %h", f, got, exp);
        end
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL sweep_frames: got %0d bad frames expected 0", bad);
      end
    end
    n_checks++;
    if (overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL sweep_overflow: got %b expected 0", overflow_o);
    end
    mon_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_midframe_reset();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
